// File: rtl/fp_addsub_seq.sv
`timescale 1ns/1ps
// Multi-cycle FADD.S/FSUB.S sequencer: issues a - b (or a - (-b)) to the shared
// subtract datapath, then normalises iteratively and packs with truncation.
module fp_addsub_seq #(
    parameter int         MAX_NORM = 24,
    parameter logic [6:0] SUB_F7   = 7'b0000100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_sub,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [2:0]  resp_flags,
    output logic        busy,
    output logic        dp_float_ctrl,
    output logic [6:0]  dp_funct_7,
    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    input  logic        dp_z_s,
    input  logic [7:0]  dp_z_e,
    input  logic [26:0] dp_z_m
);

    localparam int                 CNT_W      = $clog2(MAX_NORM + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(MAX_NORM);
    localparam logic signed [9:0]  E_MIN      = -10'sd126;
    localparam logic signed [9:0]  E_BIAS     = 10'sd127;
    localparam logic signed [9:0]  BIASED_INF = 10'sd255;
    localparam logic [31:0]        QNAN       = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_NORM,
        S_PACK,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_s;
    logic signed [9:0]       r_e;
    logic [24:0]             r_m;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_preset;
    logic [31:0]             r_dp_a;
    logic [31:0]             r_dp_b;
    logic [31:0]             r_resp_data;
    logic [2:0]              r_resp_flags;

    logic                    w_special;
    logic                    w_dp_zero;
    logic                    w_shift_r;
    logic                    w_shift_l;
    logic signed [9:0]       w_biased;
    logic                    w_ovf;
    logic [31:0]             w_packed;
    logic [2:0]              w_packed_flags;
    logic                    w_unused_ok;

    assign w_special = (dp_z_e == 8'hFF);
    assign w_dp_zero = (dp_z_m[24:0] == 25'd0);

    // Right shift (carry) has priority; left shifts stop at the subnormal floor.
    assign w_shift_r = r_m[24];
    assign w_shift_l = !r_m[23] && (r_e > E_MIN) && (r_cnt < CNT_MAX);

    assign w_biased = r_e + E_BIAS;
    assign w_ovf    = (w_biased >= BIASED_INF);
    assign w_packed = w_ovf     ? {r_s, 8'hFF, 23'd0} :
                      !r_m[23]  ? {r_s, 8'h00, r_m[22:0]} :
                                  {r_s, w_biased[7:0], r_m[22:0]};
    assign w_packed_flags = {1'b0, w_ovf, (w_packed[30:0] == 31'd0)};

    // Bit 25 of the datapath magnitude carries no information for this sequencer.
    assign w_unused_ok = dp_z_m[25];

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (req_valid) w_state_nxt = S_EVAL;
            S_EVAL: w_state_nxt = (w_special || w_dp_zero) ? S_PACK : S_NORM;
            S_NORM: if (!w_shift_r && !w_shift_l) w_state_nxt = S_PACK;
            S_PACK: w_state_nxt = S_DONE;
            S_DONE: if (resp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (reset) begin
            r_s          <= 1'b0;
            r_e          <= '0;
            r_m          <= '0;
            r_cnt        <= '0;
            r_preset     <= 1'b0;
            r_dp_a       <= '0;
            r_dp_b       <= '0;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_dp_a <= req_a;
                        r_dp_b <= req_sub ? req_b : {~req_b[31], req_b[30:0]};
                    end
                end
                S_EVAL: begin
                    r_s      <= dp_z_s;
                    r_e      <= {{2{dp_z_e[7]}}, dp_z_e};
                    r_m      <= dp_z_m[24:0];
                    r_cnt    <= '0;
                    r_preset <= w_special || w_dp_zero;
                    if (w_special) begin
                        r_resp_data  <= dp_z_m[26] ? QNAN : {dp_z_s, 8'hFF, 23'd0};
                        r_resp_flags <= dp_z_m[26] ? 3'b100 : 3'b000;
                    end else if (w_dp_zero) begin
                        r_resp_data  <= 32'd0;
                        r_resp_flags <= 3'b001;
                    end
                end
                S_NORM: begin
                    if (w_shift_r) begin
                        r_m <= r_m >> 1;
                        r_e <= r_e + 10'sd1;
                    end else if (w_shift_l) begin
                        r_m   <= r_m << 1;
                        r_e   <= r_e - 10'sd1;
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PACK: begin
                    if (!r_preset) begin
                        r_resp_data  <= w_packed;
                        r_resp_flags <= w_packed_flags;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign busy          = (r_state != S_IDLE);
    assign resp_valid    = (r_state == S_DONE);
    assign dp_float_ctrl = (r_state == S_EVAL);
    assign dp_funct_7    = SUB_F7;
    assign dp_a          = r_dp_a;
    assign dp_b          = r_dp_b;
    assign resp_data     = r_resp_data;
    assign resp_flags    = r_resp_flags;

endmodule
